// File: rtl/wishbone_board_mem_mp.sv
// Multi-port board memory with one write slave, NUM_RD read slaves, and a clear sweep run on reset and on request.
// Optional macro BOARD_MEM_PARITY_EN stores an even-parity bit per cell and adds the rd_err_o output.
module wishbone_board_mem_mp #(
    parameter int unsigned BOARD_SIZE = 16,
    parameter int unsigned CELL_W     = 8,
    parameter int unsigned NUM_RD     = 2,
    localparam int unsigned ADDR_W    = $clog2(BOARD_SIZE * BOARD_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    output logic                     busy_o,
    input  logic                     wr_cyc_i,
    input  logic                     wr_stb_i,
    input  logic                     wr_we_i,
    input  logic [ADDR_W-1:0]        wr_adr_i,
    input  logic [CELL_W-1:0]        wr_dat_i,
    output logic                     wr_ack_o,
    input  logic [NUM_RD-1:0]        rd_cyc_i,
    input  logic [NUM_RD-1:0]        rd_stb_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_adr_i,
    output logic [NUM_RD*CELL_W-1:0] rd_dat_o,
`ifdef BOARD_MEM_PARITY_EN
    output logic [NUM_RD-1:0]        rd_err_o,
`endif
    output logic [NUM_RD-1:0]        rd_ack_o
);

    localparam int unsigned CELLS = BOARD_SIZE * BOARD_SIZE;
`ifdef BOARD_MEM_PARITY_EN
    localparam int unsigned MEM_W = CELL_W + 1;
`else
    localparam int unsigned MEM_W = CELL_W;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              wr_take;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [MEM_W-1:0]  mem_wd;
    logic              idle;

    logic [MEM_W-1:0]  mem [CELLS];

    logic [ADDR_W-1:0] rd_adr  [NUM_RD];
    logic [MEM_W-1:0]  rd_word [NUM_RD];
    logic [NUM_RD-1:0] rd_take;

    // Indices past the last cell exist when BOARD_SIZE is not a power of two.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(CELLS);
    endfunction

    assign idle = (state_q == IDLE);

    // Next state, sweep counter and the single memory write port.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_take = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = wr_adr_i;
`ifdef BOARD_MEM_PARITY_EN
        mem_wd  = {^wr_dat_i, wr_dat_i};
`else
        mem_wd  = wr_dat_i;
`endif
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (wr_cyc_i && wr_stb_i && !wr_ack_o) begin
                    wr_take = 1'b1;
                    mem_we  = wr_we_i && in_range(wr_adr_i);
                end
            end
            CLEAR: begin
                // A zero word has even parity 0, so the all-zero pattern is a valid cleared cell.
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                if (cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            busy_o   <= 1'b1;
            wr_ack_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_o   <= (state_d == CLEAR);
            wr_ack_o <= wr_take;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Read ports sample the array before this cycle's write lands, giving read-first behaviour.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_adr[k]  = rd_adr_i[k*ADDR_W +: ADDR_W];
            rd_take[k] = idle && rd_cyc_i[k] && rd_stb_i[k] && !rd_ack_o[k];
            rd_word[k] = in_range(rd_adr[k]) ? mem[rd_adr[k]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack_o <= '0;
            rd_dat_o <= '0;
`ifdef BOARD_MEM_PARITY_EN
            rd_err_o <= '0;
`endif
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_ack_o[k] <= rd_take[k];
                if (rd_take[k]) begin
                    rd_dat_o[k*CELL_W +: CELL_W] <= rd_word[k][CELL_W-1:0];
`ifdef BOARD_MEM_PARITY_EN
                    rd_err_o[k] <= ^rd_word[k];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_wishbone_board_mem_mp.sv
// Scoreboard bench for wishbone_board_mem_mp: a 16x16 two-port instance plus a 10x10 one-port instance.
module tb_wishbone_board_mem_mp;

    localparam int unsigned CW  = 8;
    localparam int unsigned NR  = 2;
    localparam int unsigned AW  = 8;
    localparam int unsigned N   = 256;
    localparam int unsigned AW10 = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear_i = 1'b0;
    logic              busy_o;
    logic              wr_cyc_i = 1'b0;
    logic              wr_stb_i = 1'b0;
    logic              wr_we_i = 1'b0;
    logic [AW-1:0]     wr_adr_i = '0;
    logic [CW-1:0]     wr_dat_i = '0;
    logic              wr_ack_o;
    logic [NR-1:0]     rd_cyc_i = '0;
    logic [NR-1:0]     rd_stb_i = '0;
    logic [NR*AW-1:0]  rd_adr_i = '0;
    logic [NR*CW-1:0]  rd_dat_o;
    logic [NR-1:0]     rd_ack_o;
`ifdef BOARD_MEM_PARITY_EN
    logic [NR-1:0]     rd_err_o;
    logic [0:0]        rd_err10;
`endif

    logic              clear10 = 1'b0;
    logic              busy10;
    logic              wcyc10 = 1'b0;
    logic              wstb10 = 1'b0;
    logic [AW10-1:0]   wadr10 = '0;
    logic [CW-1:0]     wdat10 = '0;
    logic              wack10;
    logic [0:0]        rcyc10 = '0;
    logic [0:0]        rstb10 = '0;
    logic [AW10-1:0]   radr10 = '0;
    logic [CW-1:0]     rdat10;
    logic [0:0]        rack10;

    int vectors = 0;
    int miscompares = 0;

    logic [CW-1:0] model [N];
    logic [CW-1:0] model10 [128];
    logic [CW-1:0] exp0 [$];
    logic [CW-1:0] exp1 [$];

    always #5 clk = ~clk;

    wishbone_board_mem_mp #(.BOARD_SIZE(16), .CELL_W(CW), .NUM_RD(NR)) u_dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .busy_o(busy_o),
        .wr_cyc_i(wr_cyc_i), .wr_stb_i(wr_stb_i), .wr_we_i(wr_we_i),
        .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i), .wr_ack_o(wr_ack_o),
        .rd_cyc_i(rd_cyc_i), .rd_stb_i(rd_stb_i), .rd_adr_i(rd_adr_i),
        .rd_dat_o(rd_dat_o),
`ifdef BOARD_MEM_PARITY_EN
        .rd_err_o(rd_err_o),
`endif
        .rd_ack_o(rd_ack_o)
    );

    wishbone_board_mem_mp #(.BOARD_SIZE(10), .CELL_W(CW), .NUM_RD(1)) u_dut10 (
        .clk(clk), .rst(rst), .clear_i(clear10), .busy_o(busy10),
        .wr_cyc_i(wcyc10), .wr_stb_i(wstb10), .wr_we_i(1'b1),
        .wr_adr_i(wadr10), .wr_dat_i(wdat10), .wr_ack_o(wack10),
        .rd_cyc_i(rcyc10), .rd_stb_i(rstb10), .rd_adr_i(radr10),
        .rd_dat_o(rdat10),
`ifdef BOARD_MEM_PARITY_EN
        .rd_err_o(rd_err10),
`endif
        .rd_ack_o(rack10)
    );

    // Drives one combined transfer from a negedge; latencies count negedge samples until ack (-1 on timeout).
    task automatic do_xfer(input logic clr, input logic wen, input logic we,
                           input logic [AW-1:0] wadr, input logic [CW-1:0] wdat,
                           input logic [NR-1:0] rmask, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           output int wlat, output int rlat,
                           output logic [CW-1:0] d0, output logic [CW-1:0] d1);
        logic          wdone;
        logic [NR-1:0] rdone;
        int            n;
        wdone = !wen; rdone = ~rmask; wlat = -1; rlat = -1; d0 = '0; d1 = '0; n = 0;
        clear_i = clr; wr_cyc_i = wen; wr_stb_i = wen; wr_we_i = we;
        wr_adr_i = wadr; wr_dat_i = wdat;
        rd_cyc_i = rmask; rd_stb_i = rmask; rd_adr_i = {a1, a0};
        while ((!wdone || rdone != 2'b11) && n < 600) begin
            @(negedge clk);
            n++;
            clear_i = 1'b0;
            if (!wdone && wr_ack_o) begin
                wdone = 1'b1; wlat = n; wr_cyc_i = 1'b0; wr_stb_i = 1'b0;
            end
            if (!rdone[0] && rd_ack_o[0]) begin
                rdone[0] = 1'b1; rlat = n; d0 = rd_dat_o[CW-1:0];
                rd_cyc_i[0] = 1'b0; rd_stb_i[0] = 1'b0;
            end
            if (!rdone[1] && rd_ack_o[1]) begin
                rdone[1] = 1'b1; rlat = n; d1 = rd_dat_o[2*CW-1:CW];
                rd_cyc_i[1] = 1'b0; rd_stb_i[1] = 1'b0;
            end
        end
        clear_i = 1'b0; wr_cyc_i = 1'b0; wr_stb_i = 1'b0; rd_cyc_i = '0; rd_stb_i = '0;
        @(negedge clk);
    endtask

    task automatic do_x10(input logic wen, input logic [AW10-1:0] wadr, input logic [CW-1:0] wdat,
                          input logic ren, input logic [AW10-1:0] radr,
                          output int wlat, output int rlat, output logic [CW-1:0] d);
        logic wdone, rdone;
        int   n;
        wdone = !wen; rdone = !ren; wlat = -1; rlat = -1; d = '0; n = 0;
        wcyc10 = wen; wstb10 = wen; wadr10 = wadr; wdat10 = wdat;
        rcyc10 = ren; rstb10 = ren; radr10 = radr;
        while ((!wdone || !rdone) && n < 600) begin
            @(negedge clk);
            n++;
            if (!wdone && wack10) begin wdone = 1'b1; wlat = n; wcyc10 = 1'b0; wstb10 = 1'b0; end
            if (!rdone && rack10[0]) begin rdone = 1'b1; rlat = n; d = rdat10; rcyc10 = 1'b0; rstb10 = 1'b0; end
        end
        wcyc10 = 1'b0; wstb10 = 1'b0; rcyc10 = 1'b0; rstb10 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt, guard, wl, rl;
        logic [CW-1:0] d0, d1, e;
        logic [AW-1:0] addrs [4];
        addrs[0] = 8'd0; addrs[1] = 8'd17; addrs[2] = 8'd128; addrs[3] = 8'd255;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rst_busy: got %b expected 1", busy_o); end
        vectors++;
        if (wr_ack_o !== 1'b0 || rd_ack_o !== 2'b00) begin
            miscompares++; $display("FAIL rst_acks: got wr=%b rd=%b expected 0/00", wr_ack_o, rd_ack_o);
        end
        vectors++;
        if (rd_dat_o !== 16'h0000) begin miscompares++; $display("FAIL rst_dat: got %h expected 0000", rd_dat_o); end
        cnt = 0; guard = 0;
        while (busy_o === 1'b1 && guard < 1000) begin cnt++; @(negedge clk); guard++; end
        vectors++;
        if (cnt != 256) begin miscompares++; $display("FAIL rst_sweep_len: got %0d expected 256", cnt); end
        for (int i = 0; i < int'(N); i++) model[i] = '0;
        for (int i = 0; i < 128; i++) model10[i] = '0;
        for (int i = 0; i < 4; i++) begin
            exp0.push_back(model[addrs[i]]);
            exp1.push_back(model[addrs[i]]);
            do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b11, addrs[i], addrs[i], wl, rl, d0, d1);
            vectors++;
            if (rl != 1) begin miscompares++; $display("FAIL rst_read_lat a=%0d: got %0d expected 1", addrs[i], rl); end
            e = exp0.pop_front();
            vectors++;
            if (d0 !== e) begin miscompares++; $display("FAIL rst_read_p0 a=%0d: got %h expected %h", addrs[i], d0, e); end
            e = exp1.pop_front();
            vectors++;
            if (d1 !== e) begin miscompares++; $display("FAIL rst_read_p1 a=%0d: got %h expected %h", addrs[i], d1, e); end
        end
    endtask

    task automatic test_write_read();
        int wl, rl;
        logic [CW-1:0] d0, d1, e;
        model[17] = 8'hA5;
        do_xfer(1'b0, 1'b1, 1'b1, 8'd17, 8'hA5, 2'b00, '0, '0, wl, rl, d0, d1);
        vectors++;
        if (wl != 1) begin miscompares++; $display("FAIL wr_lat: got %0d expected 1", wl); end
        exp0.push_back(model[17]);
        do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b01, 8'd17, '0, wl, rl, d0, d1);
        vectors++;
        if (rl != 1) begin miscompares++; $display("FAIL rd_lat: got %0d expected 1", rl); end
        e = exp0.pop_front();
        vectors++;
        if (d0 !== e) begin miscompares++; $display("FAIL rd_data17: got %h expected %h", d0, e); end
    endtask

    task automatic test_read_first();
        int wl, rl;
        logic [CW-1:0] d0, d1, e;
        model[5] = 8'h11;
        do_xfer(1'b0, 1'b1, 1'b1, 8'd5, 8'h11, 2'b00, '0, '0, wl, rl, d0, d1);
        exp0.push_back(model[5]);
        exp1.push_back(model[5]);
        model[5] = 8'h3C;
        do_xfer(1'b0, 1'b1, 1'b1, 8'd5, 8'h3C, 2'b11, 8'd5, 8'd5, wl, rl, d0, d1);
        vectors++;
        if (wl != 1 || rl != 1) begin miscompares++; $display("FAIL rf_lat: got w=%0d r=%0d expected 1/1", wl, rl); end
        e = exp0.pop_front();
        vectors++;
        if (d0 !== e) begin miscompares++; $display("FAIL rf_old_p0: got %h expected %h", d0, e); end
        e = exp1.pop_front();
        vectors++;
        if (d1 !== e) begin miscompares++; $display("FAIL rf_old_p1: got %h expected %h", d1, e); end
        exp0.push_back(model[5]);
        exp1.push_back(model[5]);
        do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b11, 8'd5, 8'd5, wl, rl, d0, d1);
        e = exp0.pop_front();
        vectors++;
        if (d0 !== e) begin miscompares++; $display("FAIL rf_new_p0: got %h expected %h", d0, e); end
        e = exp1.pop_front();
        vectors++;
        if (d1 !== e) begin miscompares++; $display("FAIL rf_new_p1: got %h expected %h", d1, e); end
    endtask

    task automatic test_out_of_range();
        int wl, rl;
        logic [CW-1:0] d, e;
        model10[99] = 8'h5A;
        do_x10(1'b1, 7'd99, 8'h5A, 1'b0, '0, wl, rl, d);
        do_x10(1'b1, 7'd100, 8'hFF, 1'b0, '0, wl, rl, d);
        vectors++;
        if (wl != 1) begin miscompares++; $display("FAIL oor_wr_ack: got lat %0d expected 1", wl); end
        exp0.push_back(8'h00);
        do_x10(1'b0, '0, '0, 1'b1, 7'd100, wl, rl, d);
        vectors++;
        if (rl != 1) begin miscompares++; $display("FAIL oor_rd_ack: got lat %0d expected 1", rl); end
        e = exp0.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL oor_rd_100: got %h expected %h", d, e); end
        exp0.push_back(8'h00);
        do_x10(1'b0, '0, '0, 1'b1, 7'd127, wl, rl, d);
        e = exp0.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL oor_rd_127: got %h expected %h", d, e); end
        exp0.push_back(model10[99]);
        do_x10(1'b0, '0, '0, 1'b1, 7'd99, wl, rl, d);
        e = exp0.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL oor_cell99: got %h expected %h", d, e); end
    endtask

    task automatic test_we_low();
        int wl, rl;
        logic [CW-1:0] d0, d1, e;
        do_xfer(1'b0, 1'b1, 1'b0, 8'd17, 8'hEE, 2'b00, '0, '0, wl, rl, d0, d1);
        vectors++;
        if (wl != 1) begin miscompares++; $display("FAIL we0_ack: got lat %0d expected 1", wl); end
        exp1.push_back(model[17]);
        do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b10, '0, 8'd17, wl, rl, d0, d1);
        e = exp1.pop_front();
        vectors++;
        if (d1 !== e) begin miscompares++; $display("FAIL we0_nochange: got %h expected %h", d1, e); end
    endtask

    task automatic test_back_to_back();
        int wl, rl;
        logic [CW-1:0] d0, d1, e;
        logic          ew;
        wr_cyc_i = 1'b1; wr_stb_i = 1'b1; wr_we_i = 1'b1; wr_adr_i = 8'd40; wr_dat_i = 8'h40;
        rd_cyc_i = 2'b01; rd_stb_i = 2'b01; rd_adr_i = {8'd0, 8'd40};
        model[40] = 8'h40;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            ew = (i % 2) == 1;
            vectors++;
            if (wr_ack_o !== ew) begin miscompares++; $display("FAIL b2b_wack s%0d: got %b expected %b", i, wr_ack_o, ew); end
            vectors++;
            if (rd_ack_o !== {1'b0, ew}) begin
                miscompares++; $display("FAIL b2b_rack s%0d: got %b expected %b", i, rd_ack_o, {1'b0, ew});
            end
        end
        wr_cyc_i = 1'b0; wr_stb_i = 1'b0; rd_cyc_i = '0; rd_stb_i = '0;
        @(negedge clk);
        exp0.push_back(model[40]);
        exp1.push_back(model[40]);
        do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b11, 8'd40, 8'd40, wl, rl, d0, d1);
        e = exp0.pop_front();
        vectors++;
        if (d0 !== e) begin miscompares++; $display("FAIL b2b_rd_p0: got %h expected %h", d0, e); end
        e = exp1.pop_front();
        vectors++;
        if (d1 !== e) begin miscompares++; $display("FAIL b2b_rd_p1: got %h expected %h", d1, e); end
    endtask

    task automatic test_clear();
        int wl, rl;
        logic [CW-1:0] d0, d1, e;
        logic [AW-1:0] addrs [3];
        model[0] = 8'h77;
        do_xfer(1'b0, 1'b1, 1'b1, 8'd0, 8'h77, 2'b00, '0, '0, wl, rl, d0, d1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL clr_busy_rise: got %b expected 1", busy_o); end
        repeat (10) @(negedge clk);
        for (int i = 0; i < int'(N); i++) model[i] = '0;
        model[200] = 8'h99;
        do_xfer(1'b0, 1'b1, 1'b1, 8'd200, 8'h99, 2'b00, '0, '0, wl, rl, d0, d1);
        vectors++;
        if (wl != 247) begin miscompares++; $display("FAIL clr_wr_wait: got lat %0d expected 247", wl); end
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL clr_busy_fall: got %b expected 0", busy_o); end
        addrs[0] = 8'd0; addrs[1] = 8'd200; addrs[2] = 8'd17;
        for (int i = 0; i < 3; i++) begin
            exp0.push_back(model[addrs[i]]);
            exp1.push_back(model[addrs[i]]);
            do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b11, addrs[i], addrs[i], wl, rl, d0, d1);
            e = exp0.pop_front();
            vectors++;
            if (d0 !== e) begin miscompares++; $display("FAIL clr_rd_p0 a=%0d: got %h expected %h", addrs[i], d0, e); end
            e = exp1.pop_front();
            vectors++;
            if (d1 !== e) begin miscompares++; $display("FAIL clr_rd_p1 a=%0d: got %h expected %h", addrs[i], d1, e); end
        end
    endtask

    task automatic test_clear_priority();
        int wl, rl;
        logic [CW-1:0] d0, d1, e;
        for (int i = 0; i < int'(N); i++) model[i] = '0;
        model[3] = 8'h66;
        do_xfer(1'b1, 1'b1, 1'b1, 8'd3, 8'h66, 2'b00, '0, '0, wl, rl, d0, d1);
        vectors++;
        if (wl != 258) begin miscompares++; $display("FAIL prio_wr_wait: got lat %0d expected 258", wl); end
        exp0.push_back(model[3]);
        exp1.push_back(model[200]);
        do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b11, 8'd3, 8'd200, wl, rl, d0, d1);
        e = exp0.pop_front();
        vectors++;
        if (d0 !== e) begin miscompares++; $display("FAIL prio_rd3: got %h expected %h", d0, e); end
        e = exp1.pop_front();
        vectors++;
        if (d1 !== e) begin miscompares++; $display("FAIL prio_rd200: got %h expected %h", d1, e); end
    endtask

    task automatic test_abort();
        int acks;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        rd_cyc_i = 2'b10; rd_stb_i = 2'b10; rd_adr_i = {8'd3, 8'd0};
        acks = 0;
        repeat (3) begin @(negedge clk); if (rd_ack_o !== 2'b00) acks++; end
        rd_cyc_i = '0; rd_stb_i = '0;
        repeat (300) begin @(negedge clk); if (rd_ack_o !== 2'b00) acks++; end
        for (int i = 0; i < int'(N); i++) model[i] = '0;
        vectors++;
        if (acks != 0) begin miscompares++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy %b expected 0", busy_o); end
    endtask

    task automatic test_reset_restart();
        int lows, cnt, guard, wl, rl;
        logic [CW-1:0] d0, d1, e;
        do_xfer(1'b0, 1'b1, 1'b1, 8'd50, 8'h12, 2'b00, '0, '0, wl, rl, d0, d1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        lows = 0;
        repeat (99) begin @(negedge clk); if (busy_o !== 1'b1) lows++; end
        vectors++;
        if (lows != 0) begin miscompares++; $display("FAIL restart_pre_busy: got %0d low samples expected 0", lows); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0; guard = 0;
        while (busy_o === 1'b1 && guard < 1000) begin cnt++; @(negedge clk); guard++; end
        vectors++;
        if (cnt != 256) begin miscompares++; $display("FAIL restart_len: got %0d expected 256", cnt); end
        for (int i = 0; i < int'(N); i++) model[i] = '0;
        exp0.push_back(model[50]);
        exp1.push_back(model[255]);
        do_xfer(1'b0, 1'b0, 1'b0, '0, '0, 2'b11, 8'd50, 8'd255, wl, rl, d0, d1);
        e = exp0.pop_front();
        vectors++;
        if (d0 !== e) begin miscompares++; $display("FAIL restart_rd50: got %h expected %h", d0, e); end
        e = exp1.pop_front();
        vectors++;
        if (d1 !== e) begin miscompares++; $display("FAIL restart_rd255: got %h expected %h", d1, e); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_first();
        test_out_of_range();
        test_we_low();
        test_back_to_back();
        test_clear();
        test_clear_priority();
        test_abort();
        test_reset_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
        $fatal(1);
    end

endmodule
